// File: rtl/decode_stage.sv
// decode_stage: instruction FIFO, registered decode and HI/LO plus load-use interlocks.
// Define DECODE_ILLEGAL_TRAP_EN to drop undecodable instructions and pulse illegal.
module decode_stage #(
    parameter int DEPTH   = 4,
    parameter int MUL_LAT = 4,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            RegDst,
    output logic            Branch,
    output logic            MemRead,
    output logic            MemtoReg,
    output logic            ALUOp,
    output logic            MULOp,
    output logic            MemWrite,
    output logic            ALUSrc,
    output logic            RegWrite,
    output logic            ShiftSel,
    output logic [5:0]      Func,
    output logic            illegal
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic       regDst;
        logic       branch;
        logic       memRead;
        logic       memtoReg;
        logic       aluOp;
        logic       mulOp;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic       shiftSel;
        logic [5:0] func;
    } ctrlT;

    logic [PC_W+31:0] mem [DEPTH];
    logic [AW:0]      wrPtr, rdPtr;
    logic [31:0]      headInstr;
    logic [PC_W-1:0]  headPc;
    logic [5:0]       opcode, funct;
    logic [4:0]       rs, rt, luReg;
    logic [3:0]       busy;
    logic             headValid, full, push, pop, load, drop, stall, legal, isMul, isMfhilo, luValid;
    ctrlT             dec, ctrlQ;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TrapEn = 1'b1;
    always_ff @(posedge clk) illegal <= rst ? 1'b0 : drop;
`else
    localparam bit TrapEn = 1'b0;
    assign illegal = 1'b0;
`endif

    assign headValid = wrPtr != rdPtr;
    assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign in_ready = !full;
    assign push = in_valid && in_ready && !flush;
    assign {headPc, headInstr} = mem[rdPtr[AW-1:0]];
    assign opcode = headInstr[31:26];
    assign funct = headInstr[5:0];
    assign rs = headInstr[25:21];
    assign rt = headInstr[20:16];

    always_comb begin
        dec = '0;
        legal = 1'b1;
        case (opcode)
            6'h00: case (funct)
                6'h20, 6'h21, 6'h22, 6'h23, 6'h00, 6'h04, 6'h03, 6'h07, 6'h02, 6'h06, 6'h24,
                6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h0b, 6'h0a, 6'h10, 6'h12, 6'h09: begin
                    dec.regDst = 1'b1;
                    dec.aluOp = 1'b1;
                    dec.regWrite = 1'b1;
                    dec.func = funct;
                end
                6'h18, 6'h19, 6'h11, 6'h13, 6'h08: begin
                    dec.aluOp = 1'b1;
                    dec.func = funct;
                end
                default: legal = 1'b0;
            endcase
            6'h1c: case (funct)
                6'h00, 6'h01, 6'h04, 6'h05: begin
                    dec.mulOp = 1'b1;
                    dec.func = funct;
                end
                6'h02: begin
                    dec.mulOp = 1'b1;
                    dec.regWrite = 1'b1;
                    dec.regDst = 1'b1;
                    dec.func = funct;
                end
                default: legal = 1'b0;
            endcase
            // ADDI/ADDIU/ANDI/ORI map their low opcode bits onto the matching R-type funct
            6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0f: begin
                dec.aluOp = 1'b1;
                dec.aluSrc = 1'b1;
                dec.regWrite = 1'b1;
                dec.shiftSel = opcode == 6'h0f;
                dec.func = (opcode == 6'h0f) ? 6'h20 : {3'b100, opcode[2:0]};
            end
            6'h23: begin
                dec.memRead = 1'b1;
                dec.memtoReg = 1'b1;
                dec.aluSrc = 1'b1;
                dec.regWrite = 1'b1;
                dec.aluOp = 1'b1;
                dec.func = 6'h21;
            end
            6'h2b: begin
                dec.memWrite = 1'b1;
                dec.aluSrc = 1'b1;
                dec.aluOp = 1'b1;
                dec.func = 6'h21;
            end
            6'h04, 6'h05: begin
                dec.branch = 1'b1;
                dec.aluOp = 1'b1;
                dec.func = 6'h22;
            end
            default: legal = 1'b0;
        endcase
    end

    assign isMul = legal && ((opcode == 6'h00 && (funct == 6'h18 || funct == 6'h19)) || opcode == 6'h1c);
    assign isMfhilo = opcode == 6'h00 && (funct == 6'h10 || funct == 6'h12);
    // HI/LO reads may issue on the edge where the counter expires, hence > 1 rather than != 0
    assign stall = (isMfhilo && busy > 4'd1) || (luValid && (rs == luReg || rt == luReg));
    assign drop = TrapEn && headValid && !legal && !flush;
    assign load = (!out_valid || out_ready) && headValid && !stall && !flush && !drop;
    assign pop = load || drop;

    always_ff @(posedge clk) if (push) mem[wrPtr[AW-1:0]] <= {in_pc, in_instr};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            wrPtr <= wrPtr + (AW+1)'(push);
            rdPtr <= rdPtr + (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) busy <= rst ? 4'd0 : (load && isMul) ? 4'(MUL_LAT) : busy - 4'(busy != 4'd0);

    // Tracks an LW(rt!=0) in the output register so its consumer is held off one slot
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            luValid <= 1'b0;
            luReg <= '0;
        end else if (load) begin
            luValid <= opcode == 6'h23 && rt != 5'd0;
            luReg <= rt;
        end else if (out_ready) begin
            luValid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc <= '0;
            ctrlQ <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_instr <= headInstr;
            out_pc <= headPc;
            ctrlQ <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign {RegDst, Branch, MemRead, MemtoReg, ALUOp, MULOp, MemWrite, ALUSrc, RegWrite, ShiftSel, Func} = ctrlQ;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (default DEPTH=4, MUL_LAT=4).
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready, out_valid, illegal;
    logic [31:0] out_instr, out_pc;
    logic        RegDst, Branch, MemRead, MemtoReg, ALUOp, MULOp, MemWrite, ALUSrc, RegWrite, ShiftSel;
    logic [5:0]  Func;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .RegDst(RegDst), .Branch(Branch),
        .MemRead(MemRead), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .MULOp(MULOp),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ShiftSel(ShiftSel),
        .Func(Func), .illegal(illegal)
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    // RegDst,Branch,MemRead,MemtoReg,ALUOp,MULOp,MemWrite,ALUSrc,RegWrite,ShiftSel
    localparam logic [9:0] R   = 10'b1000100010;
    localparam logic [9:0] RN  = 10'b0000100000;
    localparam logic [9:0] MU  = 10'b1000010010;
    localparam logic [9:0] MA  = 10'b0000010000;
    localparam logic [9:0] IM  = 10'b0000100110;
    localparam logic [9:0] LU  = 10'b0000100111;
    localparam logic [9:0] LDW = 10'b0011100110;
    localparam logic [9:0] STW = 10'b0000101100;
    localparam logic [9:0] BR  = 10'b0100100000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [15:0] ctl;
    } expT;

    typedef struct packed {
        logic [31:0] i;
        logic [15:0] c;
        logic        ill;
    } stimT;

    stimT tbl [24] = '{
        {32'h00221820, R, 6'h20, 1'b0}, {32'h00221823, R, 6'h23, 1'b0},
        {32'h00021900, R, 6'h00, 1'b0}, {32'h00221807, R, 6'h07, 1'b0},
        {32'h00221827, R, 6'h27, 1'b0}, {32'h0022182B, R, 6'h2b, 1'b0},
        {32'h0022180A, R, 6'h0a, 1'b0}, {32'h0020F809, R, 6'h09, 1'b0},
        {32'h00200008, RN, 6'h08, 1'b0}, {32'h00200013, RN, 6'h13, 1'b0},
        {32'h00220019, RN, 6'h19, 1'b0}, {32'h70221802, MU, 6'h02, 1'b0},
        {32'h70220005, MA, 6'h05, 1'b0}, {32'h24010005, IM, 6'h21, 1'b0},
        {32'h304100FF, IM, 6'h24, 1'b0}, {32'h344100FF, IM, 6'h25, 1'b0},
        {32'h3C011234, LU, 6'h20, 1'b0}, {32'hFC000000, 10'b0, 6'h00, 1'b1},
        {32'hAC220004, STW, 6'h21, 1'b0}, {32'h10220008, BR, 6'h22, 1'b0},
        {32'h14220008, BR, 6'h22, 1'b0}, {32'h8C250000, LDW, 6'h21, 1'b0},
        {32'h00221821, R, 6'h21, 1'b0}, {32'h0000003F, 10'b0, 6'h00, 1'b1}
    };

    expT         sbQ[$];
    expT         mon;
    int          hsQ[$];
    int          checks = 0, errors = 0, cyc = 0, illCnt = 0;
    logic [31:0] pcCnt = 32'h1000;
    wire  [15:0] outCtl = {RegDst, Branch, MemRead, MemtoReg, ALUOp, MULOp, MemWrite, ALUSrc, RegWrite, ShiftSel, Func};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        cyc++;
        if (illegal === 1'b1) illCnt++;
        if (out_valid && out_ready) begin
            hsQ.push_back(cyc);
            if (sbQ.size() == 0) chk("sb_extra", 64'(sbQ.size()), 64'd1);
            else begin
                mon = sbQ.pop_front();
                chk("out_instr", out_instr, mon.instr);
                chk("out_pc", out_pc, mon.pc);
                chk("out_ctl", outCtl, mon.ctl);
            end
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [15:0] ctl, input logic ill = 1'b0);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("push_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc = pcCnt;
        if (!(ill && Trap)) sbQ.push_back('{instr, pcCnt, ctl});
        pcCnt += 4;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (sbQ.size() == 0 && !out_valid) break;
        end
        chk("drain", 64'(sbQ.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_illegal", illegal, 0);
        chk("rst_ctl", outCtl, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        rst = 1'b0;

        out_ready = 1'b1;
        drive(32'h20010005, {IM, 6'h20});
        chk("lat_k", out_valid, 0);
        @(negedge clk);
        chk("lat_k1", out_valid, 1);
        chk("addi_func", Func, 6'h20);
        drain();

        hsQ.delete();
        illCnt = 0;
        foreach (tbl[i]) drive(tbl[i].i, tbl[i].c, tbl[i].ill);
        drain();
        chk("throughput", hsQ[$] - hsQ[0], 23);
        chk("illegal_pulses", illCnt, Trap ? 2 : 0);

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(32'h00221820 + (i << 11), {R, 6'h20});
        chk("full_in_ready", in_ready, 0);
        chk("hold_instr", out_instr, 32'h00221820);
        repeat (3) @(negedge clk);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_valid", out_valid, 1);
        chk("hold_instr2", out_instr, 32'h00221820);
        out_ready = 1'b1;
        drain();

        hsQ.delete();
        drive(32'h00220018, {RN, 6'h18});
        drive(32'h00002010, {R, 6'h10});
        drain();
        chk("mfhi_gap", hsQ[1] - hsQ[0], 4);

        hsQ.delete();
        drive(32'h8C220000, {LDW, 6'h21});
        drive(32'h00421820, {R, 6'h20});
        drain();
        chk("lu_gap", hsQ[1] - hsQ[0], 2);
        hsQ.delete();
        drive(32'h8C200000, {LDW, 6'h21});
        drive(32'h00421820, {R, 6'h20});
        drain();
        chk("lu0_gap", hsQ[1] - hsQ[0], 1);

        out_ready = 1'b0;
        drive(32'h00221820, {R, 6'h20});
        drive(32'h00220018, {RN, 6'h18});
        drive(32'h00221821, {R, 6'h21});
        drive(32'h00221822, {R, 6'h22});
        out_ready = 1'b1;
        drive(32'h00221823, {R, 6'h23});
        out_ready = 1'b0;
        flush = 1'b1;
        sbQ.delete();
        @(negedge clk);
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        drive(32'h00002012, {R, 6'h12});
        @(negedge clk);
        chk("mflo_wait", out_valid, 0);
        @(negedge clk);
        chk("mflo_go", out_valid, 1);
        chk("mflo_instr", out_instr, 32'h00002012);
        drain();

        in_valid = 1'b1;
        in_instr = 32'h00221820;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_push", out_valid, 0);

        out_ready = 1'b0;
        drive(32'h00220018, {RN, 6'h18});
        drive(32'h00002010, {R, 6'h10});
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        sbQ.delete();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_in_ready", in_ready, 1);
        chk("rst2_pc", out_pc, 0);
        chk("rst2_ctl", outCtl, 0);
        out_ready = 1'b1;
        drive(32'h00002012, {R, 6'h12});
        @(negedge clk);
        chk("rst2_busy_clear", out_valid, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
